// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        TOUT = 2'd3
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Width of the watchdog counter; at least one bit so a disabled watchdog still elaborates.
    function automatic int wdt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_arb_wdt.sv
// Bus watchdog: down-counter reloaded with TIMEOUT, expires at terminal count zero.
module wb_arb_wdt
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = wdt_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD_VAL;
        end else if (clr) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // TIMEOUT of zero leaves the counter parked at zero and never expires.
    assign expire = (TIMEOUT != 0) && (cnt == '0);

endmodule

// File: rtl/wb_arb2.sv
// Round-robin two-master to one-slave Wishbone B4 arbiter with a bus watchdog.
//   state | meaning
//   IDLE  | no owner, arbitrate requests
//   GNT0  | master 0 owns the slave for its cyc tenure
//   GNT1  | master 1 owns the slave for its cyc tenure
//   TOUT  | watchdog fired; slave isolated until the owner drops cyc
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            wbm0_cyc_i,
    input  logic            wbm0_stb_i,
    input  logic            wbm0_we_i,
    input  logic [AW-1:0]   wbm0_adr_i,
    input  logic [DW-1:0]   wbm0_dat_i,
    input  logic [DW/8-1:0] wbm0_sel_i,
    output logic [DW-1:0]   wbm0_dat_o,
    output logic            wbm0_ack_o,
    output logic            wbm0_err_o,
    input  logic            wbm1_cyc_i,
    input  logic            wbm1_stb_i,
    input  logic            wbm1_we_i,
    input  logic [AW-1:0]   wbm1_adr_i,
    input  logic [DW-1:0]   wbm1_dat_i,
    input  logic [DW/8-1:0] wbm1_sel_i,
    output logic [DW-1:0]   wbm1_dat_o,
    output logic            wbm1_ack_o,
    output logic            wbm1_err_o,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    output logic            wbs_we_o,
    output logic [AW-1:0]   wbs_adr_o,
    output logic [DW-1:0]   wbs_dat_o,
    output logic [DW/8-1:0] wbs_sel_o,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i,
    output logic [1:0]      grant_o,
    output logic            tout_o
);

    arb_state_t state;
    logic       last;
    logic       owner;
    logic       tout_q;
    logic [1:0] grant_q;

    logic req0, req1, in_gnt, own_idx, own_cyc, stall, wdt_exp;

    assign req0    = wbm0_cyc_i & wbm0_stb_i;
    assign req1    = wbm1_cyc_i & wbm1_stb_i;
    assign in_gnt  = (state == GNT0) || (state == GNT1);
    // In TOUT the registered owner still decides whose cyc ends the penalty.
    assign own_idx = (state == TOUT) ? owner : (state == GNT1);
    assign own_cyc = own_idx ? wbm1_cyc_i : wbm0_cyc_i;

    assign wbs_cyc_o = in_gnt & own_cyc;
    assign wbs_stb_o = in_gnt & (own_idx ? wbm1_stb_i : wbm0_stb_i);
    assign wbs_we_o  = in_gnt & (own_idx ? wbm1_we_i  : wbm0_we_i);
    assign wbs_adr_o = own_idx ? wbm1_adr_i : wbm0_adr_i;
    assign wbs_dat_o = own_idx ? wbm1_dat_i : wbm0_dat_i;
    assign wbs_sel_o = own_idx ? wbm1_sel_i : wbm0_sel_i;

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;
    assign wbm0_ack_o = (state == GNT0) & wbs_ack_i;
    assign wbm1_ack_o = (state == GNT1) & wbs_ack_i;
    assign wbm0_err_o = ((state == GNT0) & wbs_err_i) | (tout_q & (owner == M0));
    assign wbm1_err_o = ((state == GNT1) & wbs_err_i) | (tout_q & (owner == M1));

    assign grant_o = grant_q;
    assign tout_o  = tout_q;

    // A termination in the expiry cycle wins over the watchdog.
    assign stall = wbs_stb_o & ~wbs_ack_i & ~wbs_err_i;

    wb_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .clr    (~wbs_cyc_o | wbs_ack_i | wbs_err_i),
        .en     (wbs_stb_o),
        .expire (wdt_exp)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state   <= IDLE;
            last    <= M1;
            owner   <= M0;
            tout_q  <= 1'b0;
            grant_q <= 2'b00;
        end else begin
            tout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last == M1)) begin
                        state   <= GNT0;
                        grant_q <= 2'b01;
                    end else if (req1) begin
                        state   <= GNT1;
                        grant_q <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!wbm0_cyc_i) begin
                        last <= M0;
                        if (req1) begin
                            state   <= GNT1;
                            grant_q <= 2'b10;
                        end else begin
                            state   <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end else if (wdt_exp && stall) begin
                        state   <= TOUT;
                        owner   <= M0;
                        tout_q  <= 1'b1;
                        grant_q <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!wbm1_cyc_i) begin
                        last <= M1;
                        if (req0) begin
                            state   <= GNT0;
                            grant_q <= 2'b01;
                        end else begin
                            state   <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end else if (wdt_exp && stall) begin
                        state   <= TOUT;
                        owner   <= M1;
                        tout_q  <= 1'b1;
                        grant_q <= 2'b00;
                    end
                end
                TOUT: begin
                    if (!own_cyc) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: arbitration, handoff, bursts, watchdog and async reset.
module tb_wb_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic            m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [AW-1:0]   m0_adr;
    logic [DW-1:0]   m0_wdat, m0_rdat;
    logic [DW/8-1:0] m0_sel;
    logic            m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [AW-1:0]   m1_adr;
    logic [DW-1:0]   m1_wdat, m1_rdat;
    logic [DW/8-1:0] m1_sel;
    logic            s_cyc, s_stb, s_we, s_ack, s_err;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat, s_rdat;
    logic [DW/8-1:0] s_sel;
    logic [1:0]      grant;
    logic            tout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbm0_cyc_i (m0_cyc),  .wbm0_stb_i (m0_stb),  .wbm0_we_i  (m0_we),
        .wbm0_adr_i (m0_adr),  .wbm0_dat_i (m0_wdat), .wbm0_sel_i (m0_sel),
        .wbm0_dat_o (m0_rdat), .wbm0_ack_o (m0_ack),  .wbm0_err_o (m0_err),
        .wbm1_cyc_i (m1_cyc),  .wbm1_stb_i (m1_stb),  .wbm1_we_i  (m1_we),
        .wbm1_adr_i (m1_adr),  .wbm1_dat_i (m1_wdat), .wbm1_sel_i (m1_sel),
        .wbm1_dat_o (m1_rdat), .wbm1_ack_o (m1_ack),  .wbm1_err_o (m1_err),
        .wbs_cyc_o  (s_cyc),   .wbs_stb_o  (s_stb),   .wbs_we_o   (s_we),
        .wbs_adr_o  (s_adr),   .wbs_dat_o  (s_wdat),  .wbs_sel_o  (s_sel),
        .wbs_dat_i  (s_rdat),  .wbs_ack_i  (s_ack),   .wbs_err_i  (s_err),
        .grant_o    (grant),
        .tout_o     (tout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_m();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    endtask

    // Ends the current tenure: owner drops cyc, the following edge returns to IDLE.
    task automatic drop_all();
        step();
        s_ack = 1'b0; s_err = 1'b0;
        idle_m();
        step();
    endtask

    initial begin
        idle_m();
        m0_adr = '0; m0_wdat = 32'h1111_0000; m0_sel = 4'hF;
        m1_adr = '0; m1_wdat = 32'h2222_0000; m1_sel = 4'h3;
        s_rdat = '0;
        rst_n  = 1'b0;

        // Reset: requests and slave terminations must not leak through
        m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1; s_err = 1'b1;
        mid();
        chk("rst_grant", grant, 2'b00);
        chk("rst_scyc", s_cyc, 1'b0);
        chk("rst_sstb", s_stb, 1'b0);
        chk("rst_tout", tout, 1'b0);
        chk("rst_ack1", m1_ack, 1'b0);
        chk("rst_err1", m1_err, 1'b0);
        step();
        rst_n = 1'b1; s_ack = 1'b0; s_err = 1'b0;
        idle_m();

        // Single read by master 1
        step();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0010;
        mid();
        chk("rd_stb_pre", s_stb, 1'b0);
        step(); mid();
        chk("rd_stb_n1", s_stb, 1'b1);
        chk("rd_adr", s_adr, 32'h0000_0010);
        chk("rd_grant", grant, 2'b10);
        chk("rd_ack_early", m1_ack, 1'b0);
        step();
        s_ack = 1'b1; s_rdat = 32'hCAFE_0001;
        mid();
        chk("rd_ack1", m1_ack, 1'b1);
        chk("rd_ack0", m0_ack, 1'b0);
        chk("rd_dat", m1_rdat, 32'hCAFE_0001);
        step();
        s_ack = 1'b0; idle_m();
        mid();
        chk("rd_scyc_drop", s_cyc, 1'b0);
        step(); mid();
        chk("rd_idle", grant, 2'b00);

        // Tie: master 0 first, direct handoff to master 1
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200;
        step();
        s_ack = 1'b1;
        mid();
        chk("tie_grant", grant, 2'b01);
        chk("tie_adr", s_adr, 32'h100);
        chk("tie_ack0", m0_ack, 1'b1);
        chk("tie_ack1", m1_ack, 1'b0);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        mid();
        chk("ho_grant_hold", grant, 2'b01);
        step(); mid();
        chk("ho_stb", s_stb, 1'b1);
        chk("ho_adr", s_adr, 32'h200);
        chk("ho_grant", grant, 2'b10);
        drop_all();

        // Master 0 burst of three strobes while master 1 waits
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300;
        step();
        for (int i = 0; i < 3; i++) begin
            m0_adr = 32'h300 + 32'(4 * i);
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200;
            s_ack  = 1'b1;
            mid();
            chk("bst_grant", grant, 2'b01);
            chk("bst_ack0", m0_ack, 1'b1);
            chk("bst_ack1", m1_ack, 1'b0);
            chk("bst_adr", s_adr, 32'h300 + 32'(4 * i));
            step();
        end
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        mid();
        chk("bst_hold", grant, 2'b01);
        step(); mid();
        chk("bst_m1_grant", grant, 2'b10);
        chk("bst_m1_adr", s_adr, 32'h200);
        drop_all();

        // Watchdog: slave never answers master 0
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h400;
        step();
        for (int k = 0; k <= TO; k++) begin
            mid();
            chk("wd_noerr", m0_err, 1'b0);
            chk("wd_stb", s_stb, 1'b1);
            step();
        end
        mid();
        chk("wd_err0", m0_err, 1'b1);
        chk("wd_tout", tout, 1'b1);
        chk("wd_err1", m1_err, 1'b0);
        chk("wd_scyc", s_cyc, 1'b0);
        chk("wd_grant", grant, 2'b00);
        step(); mid();
        chk("wd_err0_once", m0_err, 1'b0);
        chk("wd_tout_once", tout, 1'b0);
        chk("wd_scyc_held", s_cyc, 1'b0);
        step();
        idle_m();
        step();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h440;
        step(); mid();
        chk("wd_back_idle", grant, 2'b10);
        drop_all();

        // Slave error passes straight through without TOUT
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        s_err = 1'b1;
        mid();
        chk("serr_err1", m1_err, 1'b1);
        chk("serr_err0", m0_err, 1'b0);
        chk("serr_tout", tout, 1'b0);
        step();
        s_err = 1'b0;
        mid();
        chk("serr_hold", grant, 2'b10);
        drop_all();

        // Strobe without cyc is ignored
        m0_stb = 1'b1;
        step(); mid();
        chk("nocyc_grant", grant, 2'b00);
        chk("nocyc_stb", s_stb, 1'b0);
        step();
        idle_m();

        // Ack on the last cycles before expiry suppresses the error
        for (int d = TO - 1; d <= TO; d++) begin
            step();
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h500;
            step();
            repeat (d) step();
            s_ack = 1'b1;
            mid();
            chk("exp_ack0", m0_ack, 1'b1);
            chk("exp_err0", m0_err, 1'b0);
            step();
            s_ack = 1'b0;
            mid();
            chk("exp_noerr_a", m0_err, 1'b0);
            chk("exp_notout", tout, 1'b0);
            chk("exp_grant", grant, 2'b01);
            step(); mid();
            chk("exp_noerr_b", m0_err, 1'b0);
            drop_all();
        end

        // Async reset mid-burst; master 0 must win the tie afterwards
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h600;
        step(); mid();
        chk("rb_grant", grant, 2'b01);
        chk("rb_scyc", s_cyc, 1'b1);
        step();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h700;
        s_ack = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rb_scyc_async", s_cyc, 1'b0);
        chk("rb_sstb_async", s_stb, 1'b0);
        chk("rb_grant_async", grant, 2'b00);
        chk("rb_ack0_async", m0_ack, 1'b0);
        chk("rb_tout_async", tout, 1'b0);
        step();
        rst_n = 1'b1; s_ack = 1'b0;
        step(); mid();
        chk("rb_tie_m0", grant, 2'b01);
        chk("rb_tie_adr", s_adr, 32'h600);
        drop_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master to one-slave Wishbone B4 arbiter that shares a single slave port (the firmware RAM) between the SCR1 instruction and data masters. It sits between the core's two Wishbone master ports and the RAM slave. Grants are round-robin and held for a whole `cyc` tenure. A bus watchdog turns a stalled slave into a Wishbone error.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; select width is `DW/8`.
- `TIMEOUT`, 255, cycles a strobed access may wait for ack/err before the arbiter errors it; 0 disables the watchdog.

Ports:
- `wb_clk_i`  in  1  single clock, all logic on rising edge.
- `wb_rst_n_i`  in  1  asynchronous, active-low reset.
- `wbm0_cyc_i`, `wbm0_stb_i`, `wbm0_we_i`  in  1 each  master 0 (instruction) controls.
- `wbm0_adr_i`  in  AW  master 0 address.
- `wbm0_dat_i`  in  DW  master 0 write data.
- `wbm0_sel_i`  in  DW/8  master 0 byte selects.
- `wbm0_dat_o`  out  DW  master 0 read data.
- `wbm0_ack_o`, `wbm0_err_o`  out  1 each  master 0 termination.
- `wbm1_*`  same set as `wbm0_*`  master 1 (data).
- `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o`  out  1 each  slave controls.
- `wbs_adr_o`  out  AW  slave address.
- `wbs_dat_o`  out  DW  slave write data.
- `wbs_sel_o`  out  DW/8  slave byte selects.
- `wbs_dat_i`  in  DW  slave read data.
- `wbs_ack_i`, `wbs_err_i`  in  1 each  slave termination.
- `grant_o`  out  2  one-hot current owner; 00 when idle or in TOUT.
- `tout_o`  out  1  one-cycle pulse on each watchdog error.

## Operation
- FSM states: IDLE, GNT0, GNT1, TOUT. Round-robin pointer `last` holds the index of the last owner.
- IDLE:
  - Request from master *i* is `wbmi_cyc_i & wbmi_stb_i`.
  - One requester: grant it.
  - Both requesting: grant the master that is not `last`.
- GNTi:
  - Slave signals are a combinational mux of master *i*; `wbs_cyc_o = wbmi_cyc_i`, `wbs_stb_o = wbmi_stb_i`.
  - `wbs_ack_i` and `wbs_err_i` route only to master *i*; the other master sees ack=err=0.
  - `wbs_dat_i` drives both `wbm*_dat_o`.
  - Grant holds while `wbmi_cyc_i` is 1, so back-to-back strobes within one `cyc` are never interleaved.
- Release: on the edge where `wbmi_cyc_i` is 0, set `last` = i.
  - Other master requesting: go directly to its GNT state (no IDLE bubble).
  - Otherwise: go to IDLE.
- Watchdog:
  - Counter clears on entering GNT and on any cycle with ack or err.
  - Increments each GNT cycle with `wbs_stb_o & !wbs_ack_i & !wbs_err_i`.
  - When it reaches TIMEOUT: go to TOUT.
- TOUT:
  - Slave cyc/stb forced 0.
  - `wbmi_err_o` = 1 and `tout_o` = 1 for the first TOUT cycle only.
  - Stay in TOUT until the owner drops cyc, then set `last` = i and go to IDLE.
- Reset values: state IDLE, `last` = 1 (master 0 wins the first tie), counter 0. All `wbs_*` controls, acks, errs, `grant_o` and `tout_o` are 0; data/address outputs are don't-care but driven.

## Timing
- Arbitration latency: request sampled at edge N; `wbs_stb_o` is high from cycle N+1.
- After grant, ack/err/read data are combinational pass-through, adding zero cycles.
- Handoff: owner drops cyc at edge K; the next owner's stb reaches the slave in cycle K+1.
- Watchdog: err reaches the master TIMEOUT+1 cycles after the first unanswered strobe cycle.
- If ack arrives in the same cycle the counter would hit TIMEOUT, ack wins and no error is raised.
- Slave `err_i` passes straight through and does not enter TOUT.
- Asynchronous reset mid-transaction: all slave controls and terminations drop immediately; the in-flight access is lost.
- A master raising stb without cyc is ignored.

## Structure
- Package `wb_arb_pkg`: state enum (IDLE, GNT0, GNT1, TOUT), master index constants, counter width = `$clog2(TIMEOUT+1)`.
- Sub-module `wb_arb_wdt`: loadable watchdog counter with clear, enable and expire outputs.
- Top `wb_arb2`: FSM, round-robin pointer, output muxes.

## Test plan
- Single read by master 1 to 0x0000_0010, slave acks next cycle → `wbs_stb_o` in cycle N+1, `wbm1_ack_o` on the same cycle as `wbs_ack_i`, `grant_o`=10.
- Both masters request at the same edge after reset → master 0 granted first. Master 0 drops cyc at edge K → master 1 stb at the slave in K+1, `grant_o`=10.
- Master 0 holds cyc for 3 strobes while master 1 requests → all 3 complete on master 0 before master 1 is granted.
- TIMEOUT=8, slave never acks → `wbm0_err_o` and `tout_o` pulse once, `wbs_cyc_o`=0 afterwards; state returns to IDLE after master drops cyc.
- Ack on the exact expiry cycle → ack delivered, no err.
- Reset asserted mid-burst → all outputs 0 asynchronously; after release, master 0 wins the first tie.
